// File: rtl/width_pack_arbiter.sv
// Round-robin arbiter sharing one 8-to-16 byte packer between NUM_REQ byte streams.
// Optional SECOND-state flush timeout enabled with `define WPA_TIMEOUT_EN.
module width_pack_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          out_data,
    output logic [ID_W-1:0]      out_id,
    output logic                 out_odd,
    output logic                 out_timeout,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, FIRST, SECOND, OUT} state_t;

    state_t                    state;
    logic [ID_W-1:0]           grant;
    logic [ID_W-1:0]           rr_ptr;
    logic [ID_W-1:0]           nxt_grant;
    logic [7:0]                hi;
    logic [NUM_REQ-1:0][7:0]   lane_data;
    logic                      sel_valid;
    logic                      sel_last;
    logic [7:0]                sel_data;
    int                        idx;
    logic                      found;

    assign lane_data = req_data;
    assign sel_valid = req_valid[grant];
    assign sel_last  = req_last[grant];
    assign sel_data  = lane_data[grant];
    assign busy      = (state != IDLE);

    always_comb begin
        req_ready = '0;
        if (state == FIRST || state == SECOND)
            req_ready[grant] = 1'b1;
    end

    // First valid requester strictly after rr_ptr, wrapping.
    always_comb begin
        nxt_grant = rr_ptr;
        found     = 1'b0;
        idx       = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                nxt_grant = ID_W'(idx);
                found     = 1'b1;
            end
        end
    end

`ifdef WPA_TIMEOUT_EN
    logic [7:0] cnt;
    logic       to_q;
    assign out_timeout = to_q;
`else
    assign out_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= ID_W'(NUM_REQ - 1);
            hi        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_odd   <= 1'b0;
`ifdef WPA_TIMEOUT_EN
            cnt       <= '0;
            to_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant <= nxt_grant;
                        state <= FIRST;
                    end
                end
                FIRST: begin
                    if (sel_valid) begin
                        hi <= sel_data;
                        if (sel_last) begin
                            out_data  <= {sel_data, 8'h00};
                            out_odd   <= 1'b1;
                            out_valid <= 1'b1;
                            out_id    <= grant;
`ifdef WPA_TIMEOUT_EN
                            to_q      <= 1'b0;
`endif
                            state     <= OUT;
                        end else begin
`ifdef WPA_TIMEOUT_EN
                            cnt   <= '0;
`endif
                            state <= SECOND;
                        end
                    end
                end
                SECOND: begin
                    // req_last is irrelevant here: the pair completes either way.
                    if (sel_valid) begin
                        out_data  <= {hi, sel_data};
                        out_odd   <= 1'b0;
                        out_valid <= 1'b1;
                        out_id    <= grant;
`ifdef WPA_TIMEOUT_EN
                        to_q      <= 1'b0;
`endif
                        state     <= OUT;
                    end
`ifdef WPA_TIMEOUT_EN
                    else if (cnt == 8'(TIMEOUT - 1)) begin
                        out_data  <= {hi, 8'h00};
                        out_odd   <= 1'b1;
                        out_valid <= 1'b1;
                        out_id    <= grant;
                        to_q      <= 1'b1;
                        state     <= OUT;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
`endif
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        rr_ptr    <= grant;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/width_pack_arbiter.md
Name: width_pack_arbiter

Overview:
Shares a single 8-to-16 byte-packing datapath between NUM_REQ byte-stream requesters.
- A round-robin arbiter grants one requester at a time.
- The grant is locked until that requester's byte pair is packed into one 16-bit word.
- The block drives the word, the source ID and an odd/pad flag to a downstream valid/ready consumer.
- It sits between the per-channel byte sources and the shared 16-bit write path.

Parameters:
NUM_REQ, 4, number of requesters (2..16).
ID_W, $clog2(NUM_REQ), width of the requester ID.
TIMEOUT, 16, cycles to wait for a second byte; used only when WPA_TIMEOUT_EN is defined (2..255).

Ports:
clk  input  1  clock, all logic on posedge.
rst_n  input  1  reset, asynchronous, active-low.
req_valid  input  NUM_REQ  per-requester byte valid.
req_data  input  NUM_REQ*8  per-requester byte; requester i uses bits [8i+7:8i].
req_last  input  NUM_REQ  byte is the final byte of the stream (flush odd byte).
req_ready  output  NUM_REQ  byte accepted when req_valid[i] & req_ready[i].
out_valid  output  1  packed word valid.
out_ready  input  1  downstream accepts the word.
out_data  output  16  packed word.
out_id  output  ID_W  requester that produced out_data.
out_odd  output  1  low byte is padding (8'h00).
out_timeout  output  1  word was flushed by timeout.
busy  output  1  state != IDLE.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_id=0, out_odd=0, out_timeout=0, busy=0, req_ready=0. Internally, rr_ptr=NUM_REQ-1 and state=IDLE.
- Requester rule: once req_valid[i] rises, it holds with stable data until accepted.
  - The block never samples a non-granted requester.
  - Retraction is a protocol violation with undefined results.
- FSM states: IDLE, FIRST, SECOND, OUT.
- req_ready is combinational from the state: only req_ready[grant] is high, and only in FIRST or SECOND. All bits are 0 otherwise.
- IDLE transition:
  - If |req_valid, set grant to the first requester with req_valid set, searching upward from rr_ptr+1 mod NUM_REQ.
  - Go to FIRST.
  - If no request, stay in IDLE.
- FIRST transition, on a byte accept:
  - Capture the byte as the high byte.
  - If req_last=1: out_data <= {byte,8'h00}, out_odd <= 1, go to OUT.
  - Else go to SECOND.
- SECOND transition, on a byte accept:
  - out_data <= {hi,byte}, out_odd <= 0, go to OUT.
  - req_last on the second byte is ignored because the pair is already complete.
- On entry to OUT, register out_valid=1 and out_id=grant. The word is visible the cycle after the accepting edge.
- OUT state:
  - Hold out_data, out_id, out_odd and out_timeout stable while out_ready=0. No requester is accepted in this state.
  - On out_valid & out_ready: out_valid <= 0, rr_ptr <= grant, go to IDLE.
- Byte order: the first byte is [15:8] and the second is [7:0], matching the existing 8-to-16 converter.
- Throughput: a minimum of 4 cycles per word (IDLE, FIRST, SECOND, OUT). An odd flush takes a minimum of 3 cycles.
- Fairness: a requester that loses arbitration is granted within NUM_REQ-1 words.
- Simultaneous requests are resolved purely by rr_ptr. The first grant after reset goes to requester 0.
- Reset asserted mid-operation clears all state immediately, and any partial pair is discarded. After release, the block starts in IDLE with rr_ptr=NUM_REQ-1.
- out_data keeps its last value after the handshake; only out_valid qualifies it.

Optional Feature:
Macro: WPA_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to SECOND and increments each SECOND cycle without an accept.
  - When the count reaches TIMEOUT-1 with no accept, the block flushes: out_data <= {hi,8'h00}, out_odd <= 1, out_timeout <= 1, go to OUT.
  - An accept in the same cycle as the expiry wins; the block packs normally with out_timeout=0.
- Not defined: out_timeout is tied 0 and SECOND waits indefinitely. No counter logic is present.

Test Plan:
- Requester 0 sends 0xA5 then 0x3C, out_ready=1 -> one word out_data=0xA53C, out_id=0, out_odd=0, out_valid high exactly 1 cycle.
- Requesters 1 and 2 both hold valid for 3 pairs each -> grants alternate 1,2,1,2,1,2, and words never mix bytes across IDs.
- Requester 3 sends 0x77 with req_last=1 -> out_data=0x7700, out_odd=1, out_id=3, and the FSM returns to IDLE after the handshake.
- A word is ready while out_ready is held low for 5 cycles -> out_valid, out_data and out_id stay stable, req_ready stays all-0; the handshake completes on cycle 6.
- rst_n is pulsed low while in SECOND after 0x12 -> all outputs are 0 at once. A new pair 0x9A,0xBC from requester 0 then yields 0x9ABC, and 0x12 never appears.
- With WPA_TIMEOUT_EN and TIMEOUT=4, requester 1 sends 0x55 and then stalls -> the flush after 4 SECOND cycles gives out_data=0x5500, out_odd=1, out_timeout=1. Without the macro the FSM stays in SECOND.
